// File: rtl/qtree_router_pkg.sv
// qtree_router_pkg
//   Shared definitions for the tree router: default parameter values and
//   helpers that locate the fields of a flit.
//   Flit layout (MSB first): {bcast[1], dest[DEST_W], payload[FLIT_W-1-DEST_W]}
package qtree_router_pkg;

   localparam int NUM_CHILD_DEF = 4;
   localparam int FLIT_W_DEF    = 40;
   localparam int DEST_W_DEF    = 6;
   localparam int CHILD_LSB_DEF = 4;
   localparam int BUF_DEPTH_DEF = 4;

   // Broadcast flag is always the flit MSB.
   function automatic int bcast_bit(input int flit_w);
      return flit_w - 1;
   endfunction

   // Bit position of dest[0] inside the flit.
   function automatic int dest_lsb(input int flit_w, input int dest_w);
      return flit_w - 1 - dest_w;
   endfunction

endpackage

// File: rtl/qtree_router_fifo.sv
// qtree_router_fifo
//   Synchronous input FIFO for one router port. Each pop produces a
//   registered one-cycle credit pulse back to the sender.
// Ports
//   clk, rst   clock, asynchronous active-low reset
//   wr, din    write strobe and flit (written on the sampling edge)
//   pop        remove the head entry (ignored when empty)
//   head       current head entry (valid only when !empty)
//   empty      FIFO holds no entry
//   credit     high for one cycle after each pop edge
module qtree_router_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         credit
);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [W-1:0]    mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CNTW-1:0] count;
   logic            full, do_wr, do_pop;

   assign full   = (count == CNTW'(DEPTH));
   assign empty  = (count == '0);
   // A write into a full FIFO is a sender protocol error; the flit is dropped.
   assign do_wr  = wr && !full;
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         credit <= 1'b0;
      end else begin
         credit <= do_pop;
         if (do_wr)  wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         case ({do_wr, do_pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr && full));

endmodule

// File: rtl/qtree_router.sv
// qtree_router
//   Tree-network router node: one parent port, NUM_CHILD child ports.
//   Downstream: parent FIFO head is routed in order, unicast to the child
//   selected by dest[CHILD_LSB +: log2(NUM_CHILD)] or broadcast to all
//   children at once. Upstream: child FIFO heads are round-robin arbitrated
//   onto the parent output.
// Flow control: a sender may emit a flit (1-cycle valid) only while it holds
//   a credit; each credit stands for one free slot in the receiver's FIFO.
//   The receiver returns one 1-cycle credit pulse per flit it pops. There is
//   no ready signal.
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   par_in_valid/data             flit from parent
//   par_upstream_credit           credit pulse to parent
//   par_out_valid/data            flit to parent (registered)
//   par_downstream_credit         credit pulse from parent
//   chd_in_valid/data             flits from children, child i at [i*FLIT_W +: FLIT_W]
//   chd_upstream_credit           credit pulses to children
//   chd_out_valid/data            flits to children (registered)
//   chd_downstream_credit         credit pulses from children
module qtree_router
   import qtree_router_pkg::*;
#(
   parameter int NUM_CHILD = NUM_CHILD_DEF,
   parameter int FLIT_W    = FLIT_W_DEF,
   parameter int DEST_W    = DEST_W_DEF,
   parameter int CHILD_LSB = CHILD_LSB_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        par_in_valid,
   input  logic [FLIT_W-1:0]           par_in_data,
   output logic                        par_upstream_credit,
   output logic                        par_out_valid,
   output logic [FLIT_W-1:0]           par_out_data,
   input  logic                        par_downstream_credit,
   input  logic [NUM_CHILD-1:0]        chd_in_valid,
   input  logic [NUM_CHILD*FLIT_W-1:0] chd_in_data,
   output logic [NUM_CHILD-1:0]        chd_upstream_credit,
   output logic [NUM_CHILD-1:0]        chd_out_valid,
   output logic [NUM_CHILD*FLIT_W-1:0] chd_out_data,
   input  logic [NUM_CHILD-1:0]        chd_downstream_credit
);
   localparam int CW        = $clog2(NUM_CHILD);
   localparam int CRW       = $clog2(BUF_DEPTH + 1);
   localparam int BCAST_BIT = bcast_bit(FLIT_W);
   localparam int SEL_LSB   = dest_lsb(FLIT_W, DEST_W) + CHILD_LSB;
   localparam logic [CRW-1:0] CRED_INIT = CRW'(BUF_DEPTH);

   logic [FLIT_W-1:0]    par_head;
   logic                 par_empty, par_pop, par_send, all_cred;
   logic [FLIT_W-1:0]    chd_head [NUM_CHILD];
   logic [NUM_CHILD-1:0] chd_empty, chd_send, grant;
   logic [CW-1:0]        sel, rr_ptr, gidx, idx;
   logic [CRW-1:0]       par_cred;
   logic [CRW-1:0]       chd_cred [NUM_CHILD];

   function automatic logic [CRW-1:0] cred_next(input logic [CRW-1:0] c,
                                                input logic sent, input logic ret);
      case ({sent, ret})
         2'b10:   return c - CRW'(1);
         2'b01:   return c + CRW'(1);
         default: return c;
      endcase
   endfunction

   qtree_router_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_par_fifo (
      .clk(clk), .rst(rst), .wr(par_in_valid), .din(par_in_data), .pop(par_pop),
      .head(par_head), .empty(par_empty), .credit(par_upstream_credit)
   );

   for (genvar g = 0; g < NUM_CHILD; g++) begin : g_chd
      qtree_router_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_chd_fifo (
         .clk(clk), .rst(rst), .wr(chd_in_valid[g]), .din(chd_in_data[g*FLIT_W +: FLIT_W]),
         .pop(grant[g]), .head(chd_head[g]), .empty(chd_empty[g]),
         .credit(chd_upstream_credit[g])
      );
      a_chd_cred: assert property (@(posedge clk) disable iff (!rst)
         !(chd_downstream_credit[g] && !chd_send[g] && chd_cred[g] == CRED_INIT));
   end

   a_par_cred: assert property (@(posedge clk) disable iff (!rst)
      !(par_downstream_credit && !par_send && par_cred == CRED_INIT));

   // Downstream routing: the head is served strictly in order. A broadcast
   // waits until every child has credit so no child ever sees a partial copy.
   always_comb begin
      chd_send = '0;
      par_pop  = 1'b0;
      all_cred = 1'b1;
      sel      = par_head[SEL_LSB +: CW];
      for (int i = 0; i < NUM_CHILD; i++) begin
         if (chd_cred[i] == '0) all_cred = 1'b0;
      end
      if (!par_empty) begin
         if (par_head[BCAST_BIT]) begin
            if (all_cred) begin
               chd_send = '1;
               par_pop  = 1'b1;
            end
         end else if (chd_cred[sel] != '0) begin
            chd_send[sel] = 1'b1;
            par_pop       = 1'b1;
         end
      end
   end

   // Upstream round-robin: scan from rr_ptr; index arithmetic wraps naturally
   // because NUM_CHILD is a power of two.
   always_comb begin
      grant    = '0;
      gidx     = rr_ptr;
      idx      = rr_ptr;
      par_send = 1'b0;
      for (int o = 0; o < NUM_CHILD; o++) begin
         idx = rr_ptr + CW'(o);
         if (!par_send && !chd_empty[idx] && par_cred != '0) begin
            par_send    = 1'b1;
            gidx        = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chd_out_valid <= '0;
         chd_out_data  <= '0;
         par_out_valid <= 1'b0;
         par_out_data  <= '0;
         par_cred      <= CRED_INIT;
         rr_ptr        <= '0;
         for (int i = 0; i < NUM_CHILD; i++) chd_cred[i] <= CRED_INIT;
      end else begin
         chd_out_valid <= chd_send;
         for (int i = 0; i < NUM_CHILD; i++) begin
            if (chd_send[i]) chd_out_data[i*FLIT_W +: FLIT_W] <= par_head;
            chd_cred[i] <= cred_next(chd_cred[i], chd_send[i], chd_downstream_credit[i]);
         end
         par_out_valid <= par_send;
         if (par_send) begin
            par_out_data <= chd_head[gidx];
            rr_ptr       <= gidx + CW'(1);
         end
         par_cred <= cred_next(par_cred, par_send, par_downstream_credit);
      end
   end

endmodule

// File: tb/tb_qtree_router.sv
// tb_qtree_router
//   Self-checking bench for qtree_router: directed scenarios plus random
//   traffic, compared every cycle against a queue-based behavioural model.
module tb_qtree_router;
   localparam int NC = 4, FW = 40, DW = 6, CL = 4, BD = 4;
   localparam int SEL_LSB = FW - 1 - DW + CL;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic             par_in_valid, par_upstream_credit, par_out_valid, par_downstream_credit;
   logic [FW-1:0]    par_in_data, par_out_data;
   logic [NC-1:0]    chd_in_valid, chd_upstream_credit, chd_out_valid, chd_downstream_credit;
   logic [NC*FW-1:0] chd_in_data, chd_out_data;

   qtree_router #(.NUM_CHILD(NC), .FLIT_W(FW), .DEST_W(DW), .CHILD_LSB(CL), .BUF_DEPTH(BD)) dut (
      .clk(clk), .rst(rst),
      .par_in_valid(par_in_valid), .par_in_data(par_in_data),
      .par_upstream_credit(par_upstream_credit),
      .par_out_valid(par_out_valid), .par_out_data(par_out_data),
      .par_downstream_credit(par_downstream_credit),
      .chd_in_valid(chd_in_valid), .chd_in_data(chd_in_data),
      .chd_upstream_credit(chd_upstream_credit),
      .chd_out_valid(chd_out_valid), .chd_out_data(chd_out_data),
      .chd_downstream_credit(chd_downstream_credit)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model state
   logic [FW-1:0] m_par_q [$];
   logic [FW-1:0] m_chd_q [NC][$];
   int            m_par_cred, m_ptr;
   int            m_chd_cred [NC];
   logic          e_par_valid, e_par_up;
   logic [FW-1:0] e_par_data;
   logic [NC-1:0] e_chd_valid, e_chd_up;
   logic [FW-1:0] e_chd_data [NC];
   // bench-side sender credits and receiver credits owed back
   int tb_par_snd, pend_par;
   int tb_chd_snd [NC];
   int pend_chd [NC];

   function automatic logic [FW-1:0] mk(input logic b, input logic [DW-1:0] d, input logic [32:0] p);
      return {b, d, p};
   endfunction

   task automatic clear_inputs();
      par_in_valid = 1'b0; par_in_data = '0; par_downstream_credit = 1'b0;
      chd_in_valid = '0;   chd_in_data = '0; chd_downstream_credit = '0;
   endtask

   task automatic model_reset();
      m_par_q.delete();
      for (int i = 0; i < NC; i++) begin
         m_chd_q[i].delete();
         m_chd_cred[i] = BD; tb_chd_snd[i] = BD; pend_chd[i] = 0;
         e_chd_data[i] = '0;
      end
      m_par_cred = BD; m_ptr = 0; tb_par_snd = BD; pend_par = 0;
      e_par_valid = 0; e_par_up = 0; e_par_data = '0; e_chd_valid = '0; e_chd_up = '0;
   endtask

   // One clock edge of the router as described by its routing rules.
   task automatic model_edge();
      logic [FW-1:0] h;
      int k, start;
      bit ok, found;
      e_par_valid = 0; e_par_up = 0; e_chd_valid = '0; e_chd_up = '0;
      if (m_par_q.size() != 0) begin
         h = m_par_q[0];
         if (h[FW-1]) begin
            ok = 1;
            for (int i = 0; i < NC; i++) if (m_chd_cred[i] == 0) ok = 0;
            if (ok) begin
               for (int i = 0; i < NC; i++) begin
                  e_chd_valid[i] = 1; e_chd_data[i] = h; m_chd_cred[i]--;
               end
               e_par_up = 1; void'(m_par_q.pop_front());
            end
         end else begin
            k = int'(h >> SEL_LSB) % NC;
            if (m_chd_cred[k] > 0) begin
               e_chd_valid[k] = 1; e_chd_data[k] = h; m_chd_cred[k]--;
               e_par_up = 1; void'(m_par_q.pop_front());
            end
         end
      end
      found = 0; start = m_ptr;
      if (m_par_cred > 0) begin
         for (int o = 0; o < NC; o++) begin
            k = (start + o) % NC;
            if (!found && m_chd_q[k].size() != 0) begin
               found = 1; e_par_valid = 1; e_par_data = m_chd_q[k].pop_front();
               e_chd_up[k] = 1; m_par_cred--; m_ptr = (k + 1) % NC;
            end
         end
      end
      if (par_downstream_credit) m_par_cred++;
      if (par_in_valid) m_par_q.push_back(par_in_data);
      for (int i = 0; i < NC; i++) begin
         if (chd_downstream_credit[i]) m_chd_cred[i]++;
         if (chd_in_valid[i]) m_chd_q[i].push_back(chd_in_data[i*FW +: FW]);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("par_out_valid", par_out_valid, e_par_valid);
      check("chd_out_valid", chd_out_valid, e_chd_valid);
      check("par_up_credit", par_upstream_credit, e_par_up);
      check("chd_up_credit", chd_upstream_credit, e_chd_up);
      if (e_par_valid) check("par_out_data", par_out_data, e_par_data);
      for (int i = 0; i < NC; i++)
         if (e_chd_valid[i]) check("chd_out_data", chd_out_data[i*FW +: FW], e_chd_data[i]);
      tb_par_snd += int'(e_par_up);
      pend_par   += int'(e_par_valid);
      for (int i = 0; i < NC; i++) begin
         tb_chd_snd[i] += int'(e_chd_up[i]);
         pend_chd[i]   += int'(e_chd_valid[i]);
      end
      clear_inputs();
   endtask

   task automatic send_par(input logic [FW-1:0] f);
      if (tb_par_snd > 0) begin
         par_in_valid = 1'b1; par_in_data = f; tb_par_snd--;
      end
   endtask

   task automatic send_chd(input int i, input logic [FW-1:0] f);
      if (tb_chd_snd[i] > 0) begin
         chd_in_valid[i] = 1'b1; chd_in_data[i*FW +: FW] = f; tb_chd_snd[i]--;
      end
   endtask

   task automatic ret_par();
      if (pend_par > 0) begin par_downstream_credit = 1'b1; pend_par--; end
   endtask

   task automatic ret_chd(input int i);
      if (pend_chd[i] > 0) begin chd_downstream_credit[i] = 1'b1; pend_chd[i]--; end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         ret_par();
         for (int i = 0; i < NC; i++) ret_chd(i);
         step();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_par_valid"}, par_out_valid, 0);
      check({tag, "_par_data"}, par_out_data, 0);
      check({tag, "_par_credit"}, par_upstream_credit, 0);
      check({tag, "_chd_valid"}, chd_out_valid, 0);
      check({tag, "_chd_data"}, chd_out_data[63:0], 0);
      check({tag, "_chd_credit"}, chd_upstream_credit, 0);
   endtask

   int cnt;

   initial begin
      rst = 1'b0;
      clear_inputs();
      model_reset();
      #3 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 1: unicast dest 6'h25 -> child 2 only, one parent credit pulse
      send_par(mk(1'b0, 6'h25, 33'h1));
      step();
      step();
      check("t1_chd_valid", chd_out_valid, 4'b0100);
      check("t1_par_credit", par_upstream_credit, 1);
      step();
      check("t1_credit_once", par_upstream_credit, 0);
      drain(4);

      // 2: broadcast stalls until child 3 regains one credit
      for (int n = 0; n < BD; n++) begin
         send_par(mk(1'b0, 6'h30, 33'(16 + n)));
         step();
      end
      step(); step();
      send_par(mk(1'b1, 6'h00, 33'h99));
      step();
      for (int n = 0; n < 4; n++) begin
         step();
         check("t2_stall", chd_out_valid, 4'b0000);
      end
      ret_chd(3);
      step();
      check("t2_wait", chd_out_valid, 4'b0000);
      step();
      check("t2_bcast_all", chd_out_valid, 4'b1111);
      drain(12);

      // 3: round-robin order 0,1,2,3,0,1,2,3 on eight consecutive cycles
      for (int c = 0; c < NC; c++) send_chd(c, mk(1'b0, 6'h0, 33'(c * 16)));
      step();
      for (int c = 0; c < NC; c++) send_chd(c, mk(1'b0, 6'h0, 33'(c * 16 + 1)));
      ret_par();
      step();
      for (int n = 0; n < 8; n++) begin
         if (n > 0) begin ret_par(); step(); end
         check("t3_valid", par_out_valid, 1);
         check("t3_src", par_out_data[7:4], n % NC);
      end
      drain(8);

      // 4: parent never returns credit; only BUF_DEPTH of 6 flits get out
      cnt = 0;
      for (int n = 0; n < 15; n++) begin
         if (n < 3) begin
            send_chd(1, mk(1'b0, 6'h0, 33'(32 + n)));
            send_chd(2, mk(1'b0, 6'h0, 33'(48 + n)));
         end
         step();
         cnt += int'(par_out_valid);
      end
      check("t4_issued", cnt, BD);
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         ret_par();
         step();
         cnt += int'(par_out_valid);
      end
      check("t4_held", cnt, 2);
      drain(10);

      // 5: send and credit return in the same cycle at counter 1
      for (int n = 0; n < 6; n++) begin
         if (n < 3) send_chd(0, mk(1'b0, 6'h0, 33'(64 + n)));
         step();
      end
      send_chd(0, mk(1'b0, 6'h0, 33'h70));
      step();
      send_chd(0, mk(1'b0, 6'h0, 33'h71));
      ret_par();
      step();
      check("t5_send", par_out_valid, 1);
      send_chd(0, mk(1'b0, 6'h0, 33'h72));
      step();
      check("t5_next", par_out_valid, 1);
      step();
      check("t5_stall", par_out_valid, 0);
      drain(12);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 1) == 1)
            send_par(mk($urandom_range(0, 7) == 0, 6'($urandom), 33'($urandom)));
         for (int i = 0; i < NC; i++)
            if ($urandom_range(0, 2) != 0) send_chd(i, mk(1'b0, 6'($urandom), 33'($urandom)));
         if ($urandom_range(0, 3) != 0) ret_par();
         for (int i = 0; i < NC; i++) if ($urandom_range(0, 3) != 0) ret_chd(i);
         step();
      end

      // 6: asynchronous reset in the middle of a burst
      for (int n = 0; n < 20; n++) begin
         send_par(mk(1'b0, 6'($urandom), 33'($urandom)));
         for (int i = 0; i < NC; i++) send_chd(i, mk(1'b0, 6'h0, 33'($urandom)));
         ret_par();
         for (int i = 0; i < NC; i++) ret_chd(i);
         step();
      end
      #2 rst = 1'b0;
      #1 check_all_zero("t6_async");
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_par(mk(1'b0, 6'h1A, 33'h5));
      step();
      step();
      check("t6_route", chd_out_valid, 4'b0010);
      cnt = 1;
      for (int n = 0; n < 10; n++) begin
         if (n < 4) send_par(mk(1'b0, 6'h10, 33'(128 + n)));
         step();
         cnt += int'(chd_out_valid[1]);
      end
      check("t6_credit4", cnt, BD);
      drain(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
